// File: rtl/axis_uart_pkg.sv
// Shared definitions for the axis_uart TX and RX paths.
//   DATA_WIDTH             bits per UART character
//   DIVIDER_WIDTH          width of the bit-period divider register
//   uart_clk_divider_reg_t clk cycles per bit
//   uart_parity_reg_t      parity mode register (bit0 odd, bit1 even)
//   uart_state_e           receiver/transmitter frame states
//   parity()               expected parity bit for a character and mode
package axis_uart_pkg;

   localparam int unsigned DATA_WIDTH    = 8;
   localparam int unsigned DIVIDER_WIDTH = 32;

   typedef logic [DIVIDER_WIDTH-1:0] uart_clk_divider_reg_t;

   typedef struct packed {
      logic [29:0] reserved;
      logic        even;
      logic        odd;
   } uart_parity_reg_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      WAIT   = 3'd5
   } uart_state_e;

   // Odd takes precedence when both mode bits are set.
   function automatic logic parity(input logic [DATA_WIDTH-1:0] data,
                                   input uart_parity_reg_t      mode);
      if (mode.odd) return ~(^data);
      return ^data;
   endfunction

endpackage

// File: rtl/axis_uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk_i   system clock
//   arstn_i asynchronous active-low reset (flops load RST_VAL)
//   d_i     asynchronous input
//   q_o     synchronised output
module axis_uart_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic arstn_i,
   input  logic d_i,
   output logic q_o
);

   logic [1:0] ff_q;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) ff_q <= {2{RST_VAL}};
      else          ff_q <= {ff_q[0], d_i};
   end

   assign q_o = ff_q[1];

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver with an AXI-Stream master output.
//   clk_i            system clock
//   arstn_i          asynchronous active-low reset
//   clk_divider_i    clk cycles per bit, latched at start detection
//   parity_i         parity mode (bit0 odd, bit1 even), latched at start
//   uart_rx_i        asynchronous serial line, idle high
//   m_axis_tdata_o   received character
//   m_axis_tvalid_o  character valid
//   m_axis_tready_i  downstream ready
//   parity_err_o     one-cycle pulse: parity mismatch (byte still delivered)
//   frame_err_o      one-cycle pulse: stop bit sampled low (byte discarded)
//   overrun_o        one-cycle pulse: byte lost, output register full
// Optional build macro AXIS_UART_RX_MAJORITY_EN: each bit decision is the
// 2-of-3 majority of the samples at cnt==2,1,0 (needs clk_divider_i >= 8).
module axis_uart_rx #(
   parameter int unsigned DATA_WIDTH    = axis_uart_pkg::DATA_WIDTH,
   parameter int unsigned DIVIDER_WIDTH = axis_uart_pkg::DIVIDER_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     arstn_i,
   input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
   input  logic [31:0]              parity_i,
   input  logic                     uart_rx_i,
   output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
   output logic                     m_axis_tvalid_o,
   input  logic                     m_axis_tready_i,
   output logic                     parity_err_o,
   output logic                     frame_err_o,
   output logic                     overrun_o
);

   import axis_uart_pkg::*;

   localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic [DIVIDER_WIDTH-1:0] CNT_ONE  = DIVIDER_WIDTH'(1);

   logic rx_s;

   axis_uart_sync #(.RST_VAL(1'b1)) u_sync (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .d_i     (uart_rx_i),
      .q_o     (rx_s)
   );

   uart_state_e              state_q, state_d;
   logic [DIVIDER_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
   logic                     odd_q, odd_d, even_q, even_d;
   logic [DATA_WIDTH-1:0]    shift_q, shift_d, tdata_q, tdata_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic                     mism_q, mism_d;
   logic                     tvalid_q, tvalid_d;
   logic                     par_err_q, par_err_d;
   logic                     frame_err_q, frame_err_d;
   logic                     overrun_q, overrun_d;
   logic                     tick, bit_val, good_stop;
   uart_parity_reg_t         mode_cur;
   logic                     unused_parity_bits;

   assign unused_parity_bits = ^parity_i[31:2];
   assign mode_cur = '{reserved: '0, even: even_q, odd: odd_q};
   assign tick     = (cnt_q == '0);

`ifdef AXIS_UART_RX_MAJORITY_EN
   // hist_q[1] holds rx_s from two cycles ago (cnt==2 at a decision),
   // hist_q[0] from the previous cycle (cnt==1).
   logic [1:0] hist_q;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) hist_q <= '1;
      else          hist_q <= {hist_q[0], rx_s};
   end

   assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
   assign bit_val = rx_s;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      div_d       = div_q;
      odd_d       = odd_q;
      even_d      = even_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      mism_d      = mism_q;
      good_stop   = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               div_d   = clk_divider_i;
               odd_d   = parity_i[0];
               even_d  = parity_i[1];
               cnt_d   = (clk_divider_i >> 1) - CNT_ONE;
               mism_d  = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (!bit_val) begin
               cnt_d   = div_q - CNT_ONE;
               idx_d   = '0;
               state_d = DATA;
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
               cnt_d   = div_q - CNT_ONE;
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) state_d = (odd_q | even_q) ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               mism_d  = (bit_val != parity(shift_q, mode_cur));
               cnt_d   = div_q - CNT_ONE;
               state_d = STOP;
            end
         end
         STOP: begin
            if (!tick) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if (bit_val) begin
               good_stop = 1'b1;
               state_d   = IDLE;
            end else begin
               frame_err_d = 1'b1;
               state_d     = WAIT;
            end
         end
         WAIT: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output register: a new byte may load in the same cycle the old one
   // handshakes; otherwise it is dropped and overrun pulses.
   always_comb begin
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      par_err_d = 1'b0;
      overrun_d = 1'b0;
      if (tvalid_q && m_axis_tready_i) tvalid_d = 1'b0;
      if (good_stop) begin
         par_err_d = mism_q;
         if (!tvalid_q || m_axis_tready_i) begin
            tdata_d  = shift_q;
            tvalid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         div_q       <= '0;
         odd_q       <= 1'b0;
         even_q      <= 1'b0;
         shift_q     <= '0;
         idx_q       <= '0;
         mism_q      <= 1'b0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         odd_q       <= odd_d;
         even_q      <= even_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         mism_q      <= mism_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         par_err_q   <= par_err_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign m_axis_tdata_o  = tdata_q;
   assign m_axis_tvalid_o = tvalid_q;
   assign parity_err_o    = par_err_q;
   assign frame_err_o     = frame_err_q;
   assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Self-checking bench for axis_uart_rx: serial frames are generated from the
// UART framing rules, expected bytes go into a scoreboard queue, and a
// monitor on the falling clock edge checks every AXI-Stream handshake.
// Build with AXIS_UART_RX_MAJORITY_EN to add the spike-rejection frame.
`timescale 1ns/1ps
module tb_axis_uart_rx;

   logic        clk;
   logic        arstn;
   logic [31:0] clk_div;
   logic [31:0] parity;
   logic        rx;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tready;
   logic        par_err;
   logic        frame_err;
   logic        overrun;

   axis_uart_rx #(.DATA_WIDTH(8), .DIVIDER_WIDTH(32)) dut (
      .clk_i           (clk),
      .arstn_i         (arstn),
      .clk_divider_i   (clk_div),
      .parity_i        (parity),
      .uart_rx_i       (rx),
      .m_axis_tdata_o  (tdata),
      .m_axis_tvalid_o (tvalid),
      .m_axis_tready_i (tready),
      .parity_err_o    (par_err),
      .frame_err_o     (frame_err),
      .overrun_o       (overrun)
   );

   typedef struct {
      logic [7:0] data;
      bit         timed;
      int         t_exp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   int   exp_par = 0, exp_frame = 0, exp_ovr = 0;
   int   n_par   = 0, n_frame   = 0, n_ovr   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: handshake checks, AXIS stability and error pulse counting.
   bit         prev_valid = 0, prev_hs = 0;
   logic [7:0] prev_data  = '0;
   int         pres_start = 0;
   exp_t       mon_e;

   always @(negedge clk) begin
      if (!arstn) begin
         prev_valid = 0;
         prev_hs    = 0;
      end else begin
         if (tvalid && (!prev_valid || prev_hs)) pres_start = cyc;
         if (prev_valid && !prev_hs) begin
            chk("tvalid_hold", {31'b0, tvalid}, 32'd1);
            chk("tdata_stable", {24'b0, tdata}, {24'b0, prev_data});
         end
         if (tvalid && tready) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_byte: got 0x%0h, none expected", tdata);
            end else begin
               mon_e = sb.pop_front();
               chk("tdata", {24'b0, tdata}, {24'b0, mon_e.data});
               if (mon_e.timed) begin
                  checks++;
                  if (pres_start < mon_e.t_exp - 1 || pres_start > mon_e.t_exp + 1) begin
                     fails++;
                     $display("FAIL tvalid_time: got cycle %0d expected %0d (+-1)", pres_start, mon_e.t_exp);
                  end
               end
            end
         end
         if (frame_err) chk("pulse_exclusive", {31'b0, par_err | overrun}, 32'd0);
         if (par_err)   n_par++;
         if (frame_err) n_frame++;
         if (overrun)   n_ovr++;
         prev_valid = tvalid;
         prev_hs    = tvalid && tready;
         prev_data  = tdata;
      end
   end

   // Drives one frame. mode: bit0 odd, bit1 even. accept=1 expects delivery,
   // accept=0 expects the byte to be lost to overrun. spike_bit is the frame
   // bit index (0 = start) that gets a 1-clk inverted spike at its centre.
   task automatic send_frame(input logic [7:0] data, input int d, input logic [1:0] mode,
                             input bit bad_par, input bit bad_stop, input int low_len,
                             input int spike_bit, input bit accept);
      bit   par_en;
      bit   pbit;
      bit   bits[$];
      exp_t e;
      int   fstart;
      par_en = (mode != 2'b00);
      if (mode[0]) pbit = (($countones(data) % 2) == 0);
      else         pbit = (($countones(data) % 2) == 1);
      if (bad_par) pbit = !pbit;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (par_en) bits.push_back(pbit);
      clk_div = d;
      parity  = {30'b0, mode};
      fstart  = cyc;
      if (bad_stop) begin
         exp_frame++;
      end else begin
         if (par_en && bad_par) exp_par++;
         if (accept) begin
            e.data  = data;
            e.timed = 1'b1;
            e.t_exp = fstart + d / 2 + 3 + bits.size() * d;
            sb.push_back(e);
         end else begin
            exp_ovr++;
         end
      end
      for (int j = 0; j < bits.size(); j++) begin
         if (j == 2) begin
            clk_div = $urandom_range(4, 60);
            parity  = $urandom;
         end
         if (j == spike_bit) begin
            rx = bits[j];  tick_n(d / 2);
            rx = !bits[j]; tick_n(1);
            rx = bits[j];  tick_n(d - d / 2 - 1);
         end else begin
            rx = bits[j];
            tick_n(d);
         end
      end
      if (bad_stop) begin
         rx = 1'b0;
         tick_n(low_len);
      end else begin
         rx = 1'b1;
         tick_n(d);
      end
      rx = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
         tick_n(1);
         n++;
      end
      chk("drain_empty", sb.size(), 32'd0);
      tick_n(5);
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_parity_err_count"}, n_par,   exp_par);
      chk({tag, "_frame_err_count"},  n_frame, exp_frame);
      chk({tag, "_overrun_count"},    n_ovr,   exp_ovr);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_tdata"},  {24'b0, tdata}, 32'd0);
      chk({tag, "_tvalid"}, {31'b0, tvalid}, 32'd0);
      chk({tag, "_perr"},   {31'b0, par_err}, 32'd0);
      chk({tag, "_ferr"},   {31'b0, frame_err}, 32'd0);
      chk({tag, "_ovr"},    {31'b0, overrun}, 32'd0);
   endtask

   initial begin
      arstn   = 1'b0;
      rx      = 1'b1;
      tready  = 1'b1;
      clk_div = 32'd16;
      parity  = 32'd0;
      #2;
      check_zero_outputs("reset");
      tick_n(3);
      arstn = 1'b1;
      tick_n(5);

      // Basic frame, no parity.
      send_frame(8'hA5, 16, 2'b00, 0, 0, 0, -1, 1);
      tick_n(4);
      drain();
      check_counts("basic");

      // Odd parity good / bad, both-bits-set (odd wins), even parity.
      send_frame(8'h03, 16, 2'b01, 0, 0, 0, -1, 1);
      tick_n(4);
      send_frame(8'h03, 16, 2'b01, 1, 0, 0, -1, 1);
      tick_n(4);
      send_frame(8'h07, 16, 2'b11, 0, 0, 0, -1, 1);
      tick_n(4);
      send_frame(8'h07, 20, 2'b10, 1, 0, 0, -1, 1);
      tick_n(4);
      drain();
      check_counts("parity");

      // Framing error, line held low, then a good frame.
      send_frame(8'h55, 16, 2'b00, 0, 1, 40, -1, 1);
      tick_n(8);
      send_frame(8'h3C, 16, 2'b00, 0, 0, 0, -1, 1);
      tick_n(4);
      drain();
      check_counts("frame");

      // Back-pressure and overrun.
      tready = 1'b0;
      send_frame(8'h11, 16, 2'b00, 0, 0, 0, -1, 1);
      tick_n(6);
      send_frame(8'h22, 16, 2'b01, 0, 0, 0, -1, 0);
      tick_n(10);
      chk("ovr_hold_tdata", {24'b0, tdata}, 32'h11);
      tready = 1'b1;
      drain();
      send_frame(8'h33, 16, 2'b00, 0, 0, 0, -1, 1);
      tick_n(4);
      drain();
      check_counts("overrun");

      // Short glitch on the idle line.
      clk_div = 32'd16;
      parity  = 32'd0;
      rx = 1'b0;
      tick_n(3);
      rx = 1'b1;
      tick_n(48);
      chk("glitch_no_byte", sb.size(), 32'd0);
      check_counts("glitch");

`ifdef AXIS_UART_RX_MAJORITY_EN
      send_frame(8'hA5, 16, 2'b00, 0, 0, 0, 4, 1);
      tick_n(4);
      send_frame(8'h5A, 24, 2'b01, 0, 0, 0, 7, 1);
      tick_n(4);
      drain();
      check_counts("majority");
`endif

      // Randomized frames.
      for (int k = 0; k < 30; k++) begin
         logic [7:0] rd;
         int         rdiv;
         logic [1:0] rmode;
         bit         rbp, rbs;
         rd    = 8'($urandom);
         rdiv  = $urandom_range(8, 40);
         rmode = 2'($urandom);
         rbp   = ($urandom_range(0, 4) == 0);
         rbs   = ($urandom_range(0, 6) == 0);
         send_frame(rd, rdiv, rmode, rbp, rbs, rdiv + $urandom_range(0, 30), -1, 1);
         tick_n($urandom_range(4, 20));
      end
      drain();
      check_counts("random");

      // Reset mid-frame with a byte pending.
      tready = 1'b0;
      send_frame(8'h5A, 16, 2'b00, 0, 0, 0, -1, 1);
      tick_n(4);
      chk("pre_reset_tvalid", {31'b0, tvalid}, 32'd1);
      clk_div = 32'd16;
      parity  = 32'd0;
      rx = 1'b0;
      tick_n(16 + 3 * 16 + 8);
      arstn = 1'b0;
      #1;
      for (int r = 0; r < 4; r++) begin
         check_zero_outputs("midreset");
         tick_n(1);
      end
      sb.delete();
      rx     = 1'b1;
      arstn  = 1'b1;
      tready = 1'b1;
      tick_n(6);
      send_frame(8'h0F, 16, 2'b00, 0, 0, 0, -1, 1);
      tick_n(4);
      drain();
      tick_n(40);
      check_counts("reset");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
